vend_dispenser: RTL and testbench

Downstream stage of the coin-counting vending FSM. It consumes that FSM's per-cycle purchase outputs (soda, change code), queues purchases, and sequences the physical actuators. For each purchase it drops one can with a done handshake and a timeout, then ejects the owed change one nickel at a time. It also reports busy, overflow, illegal-code and fault status to the system controller.

---
 rtl/vend_dispenser_if.sv | 36 +++
 rtl/vend_dispenser.sv | 159 +++++++++++++++
 tb/tb_vend_dispenser.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispenser_if
// Description : Purchase, actuator and status signals between the vending
//               FSM / system controller (master) and the dispenser (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vend_dispenser_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                                soda_i;
    logic [2:0]                          chan_i;
    logic                                can_done_i;
    logic                                nick_ready_i;
    logic                                can_drop_o;
    logic                                nick_eject_o;
    logic                                busy_o;
    logic [$clog2(FIFO_DEPTH + 1)-1:0]   pend_o;
    logic [15:0]                         vend_cnt_o;
    logic                                overflow_o;
    logic                                code_err_o;
    logic                                fault_o;

    modport master (
        output soda_i, chan_i, can_done_i, nick_ready_i,
        input  can_drop_o, nick_eject_o, busy_o, pend_o, vend_cnt_o,
               overflow_o, code_err_o, fault_o
    );

    modport slave (
        input  soda_i, chan_i, can_done_i, nick_ready_i,
        output can_drop_o, nick_eject_o, busy_o, pend_o, vend_cnt_o,
               overflow_o, code_err_o, fault_o
    );
endinterface
`default_nettype wire

// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispenser
// Description : Queues purchases from the vending FSM, drops one can per
//               purchase, then ejects the owed change one nickel at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispenser #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_TIMEOUT = 255,
    parameter int EJECT_GAP    = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vend_dispenser_if.slave bus
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);
    localparam int c_tw = $clog2(DROP_TIMEOUT + 1);
    localparam int c_gw = $clog2(EJECT_GAP + 1);
    localparam logic [c_cw-1:0] c_full     = c_cw'(FIFO_DEPTH);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(DROP_TIMEOUT - 1);
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(EJECT_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DROP   = 3'd1,
        S_CHANGE = 3'd2,
        S_GAP    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_fifo [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [2:0]      r_remain;
    logic [c_tw-1:0] r_timer;
    logic [c_gw-1:0] r_gap;
    logic            r_can_drop;
    logic            r_nick_eject;
    logic [15:0]     r_vend_cnt;
    logic            r_overflow;
    logic            r_code_err;
    logic            r_fault;

    logic w_code_bad;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_code_bad = bus.soda_i && (bus.chan_i > 3'd4);
    assign w_push_req = bus.soda_i && !w_code_bad;
    assign w_full     = (r_count == c_full);
    // Pop decision uses occupancy before this edge's push, so a purchase
    // arriving into an empty queue is started one edge later.
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.chan_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_code_bad)                     r_code_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_remain     <= 3'd0;
            r_timer      <= '0;
            r_gap        <= '0;
            r_can_drop   <= 1'b0;
            r_nick_eject <= 1'b0;
            r_vend_cnt   <= 16'd0;
            r_fault      <= 1'b0;
        end else begin
            r_nick_eject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_remain   <= r_fifo[r_rd_ptr];
                        r_can_drop <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.can_done_i) begin
                        r_can_drop <= 1'b0;
                        r_vend_cnt <= r_vend_cnt + 16'd1;
                        r_timer    <= '0;
                        r_state    <= (r_remain != 3'd0) ? S_CHANGE : S_IDLE;
                    end else if (r_timer == c_tmo_last) begin
                        r_can_drop <= 1'b0;
                        r_fault    <= 1'b1;
                        r_state    <= S_FAULT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_CHANGE: begin
                    if (bus.nick_ready_i) begin
                        r_nick_eject <= 1'b1;
                        r_remain     <= r_remain - 3'd1;
                        r_gap        <= '0;
                        r_state      <= (r_remain == 3'd1) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    // The pulse cycle is the first gap cycle, so the idle
                    // time between pulses equals EJECT_GAP.
                    if (r_gap == c_gap_last) begin
                        r_state <= S_CHANGE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_FAULT: begin
                    r_can_drop <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.can_drop_o   = r_can_drop;
    assign bus.nick_eject_o = r_nick_eject;
    assign bus.busy_o       = (r_state != S_IDLE) || (r_count != '0);
    assign bus.pend_o       = r_count;
    assign bus.vend_cnt_o   = r_vend_cnt;
    assign bus.overflow_o   = r_overflow;
    assign bus.code_err_o   = r_code_err;
    assign bus.fault_o      = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_dispenser
// Description : Scoreboard bench: purchase stream vs. observed drops/nickels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispenser;
    localparam int FIFO_DEPTH   = 4;
    localparam int DROP_TIMEOUT = 255;
    localparam int EJECT_GAP    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vend_dispenser_if #(.FIFO_DEPTH(FIFO_DEPTH)) vif ();

    vend_dispenser #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DROP_TIMEOUT(DROP_TIMEOUT),
        .EJECT_GAP   (EJECT_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: change owed by each accepted purchase, in order.
    int exp_q[$];
    bit mon_active = 1'b0;
    int cur_exp    = 0;
    int cur_nick   = 0;
    int last_pulse = -1000;
    int cyc        = 0;
    bit prev_drop  = 1'b0;
    bit prev_nick  = 1'b0;
    bit ready_prev = 1'b0;

    bit auto_done   = 1'b0;
    bit auto_ready  = 1'b0;
    bit toggle_rdy  = 1'b0;
    int tcnt        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic flush();
        if (mon_active) begin
            chk("nick_count", cur_nick, cur_exp);
            mon_active = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_drop  = 1'b0;
            prev_nick  = 1'b0;
            ready_prev = 1'b0;
        end else begin
            cyc++;
            if (vif.can_drop_o && !prev_drop) begin
                flush();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drop_unexpected: got a can drop, required none");
                end else begin
                    cur_exp    = exp_q.pop_front();
                    cur_nick   = 0;
                    mon_active = 1'b1;
                    last_pulse = -1000;
                end
            end
            if (vif.nick_eject_o) begin
                cur_nick++;
                chk("nick_excess_ok", (mon_active && cur_nick <= cur_exp), 1);
                chk("nick_after_ready", ready_prev, 1);
                chk("nick_single_cycle", prev_nick, 0);
                chk("nick_gap_ok", ((cyc - last_pulse) > EJECT_GAP), 1);
                chk("nick_while_drop", vif.can_drop_o, 0);
                last_pulse = cyc;
            end
            prev_drop  = vif.can_drop_o;
            prev_nick  = vif.nick_eject_o;
            ready_prev = vif.nick_ready_i;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_done)  vif.can_done_i   = vif.can_drop_o && ($urandom_range(0, 3) == 0);
        if (auto_ready) vif.nick_ready_i = ($urandom_range(0, 1) == 1);
        if (toggle_rdy) begin
            tcnt++;
            vif.nick_ready_i = ((tcnt / 3) % 2) == 0;
        end
    endtask

    task automatic do_reset();
        mon_active       = 1'b0;
        exp_q.delete();
        auto_done        = 1'b0;
        auto_ready       = 1'b0;
        toggle_rdy       = 1'b0;
        vif.soda_i       = 1'b0;
        vif.chan_i       = 3'd0;
        vif.can_done_i   = 1'b0;
        vif.nick_ready_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic issue(input int c, input bit accepted);
        vif.soda_i = 1'b1;
        vif.chan_i = c[2:0];
        if (accepted) exp_q.push_back(c);
        cycle();
        vif.soda_i = 1'b0;
    endtask

    initial begin
        int n_legal;
        bit any_bad;
        int cnt;
        int p0, p1, np;

        vif.soda_i = 1'b0; vif.chan_i = 3'd0;
        vif.can_done_i = 1'b0; vif.nick_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_can_drop", vif.can_drop_o, 0);
        chk("rst_nick", vif.nick_eject_o, 0);
        chk("rst_busy", vif.busy_o, 0);
        chk("rst_pend", vif.pend_o, 0);
        chk("rst_vend", vif.vend_cnt_o, 0);
        chk("rst_flags", {vif.overflow_o, vif.code_err_o, vif.fault_o}, 0);

        // Single purchase with two nickels
        do_reset();
        vif.nick_ready_i = 1'b1;
        issue(2, 1'b1);
        chk("t1_drop_e0", vif.can_drop_o, 0);
        chk("t1_pend_e0", vif.pend_o, 1);
        cycle();
        chk("t1_drop_e1", vif.can_drop_o, 1);
        chk("t1_pend_e1", vif.pend_o, 0);
        chk("t1_busy", vif.busy_o, 1);
        cycle(); cycle();
        vif.can_done_i = 1'b1;
        cycle();
        vif.can_done_i = 1'b0;
        chk("t1_drop_off", vif.can_drop_o, 0);
        chk("t1_vend", vif.vend_cnt_o, 1);
        p0 = -1; p1 = -1; np = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (vif.nick_eject_o) begin
                if (np == 0) p0 = i;
                else if (np == 1) p1 = i;
                np++;
            end
        end
        chk("t1_pulses", np, 2);
        chk("t1_first_pulse", p0, 0);
        chk("t1_pulse_spacing", p1 - p0, EJECT_GAP + 1);
        chk("t1_busy_end", vif.busy_o, 0);
        flush();

        // Queue fill and overflow
        do_reset();
        for (int k = 0; k < 6; k++) begin
            issue(0, k < 5);
            if (k == 4) begin
                chk("t2_no_ovf_yet", vif.overflow_o, 0);
                chk("t2_pend_full", vif.pend_o, 4);
            end
        end
        chk("t2_overflow", vif.overflow_o, 1);
        chk("t2_pend", vif.pend_o, 4);
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (!vif.can_drop_o && cnt < 10) begin
                cycle();
                cnt++;
            end
            chk("t2_drop_seen", vif.can_drop_o, 1);
            vif.can_done_i = 1'b1;
            cycle();
            vif.can_done_i = 1'b0;
        end
        repeat (3) cycle();
        chk("t2_vend", vif.vend_cnt_o, 5);
        chk("t2_pend_end", vif.pend_o, 0);
        chk("t2_busy_end", vif.busy_o, 0);
        flush();

        // Illegal change code
        do_reset();
        issue(6, 1'b0);
        repeat (3) cycle();
        chk("t3_no_drop", vif.can_drop_o, 0);
        chk("t3_code_err", vif.code_err_o, 1);
        chk("t3_pend", vif.pend_o, 0);
        chk("t3_overflow", vif.overflow_o, 0);

        // Drop timeout
        do_reset();
        issue(1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (vif.can_drop_o) cnt++;
            if (vif.fault_o) break;
        end
        chk("t4_fault", vif.fault_o, 1);
        chk("t4_drop_cycles", cnt, DROP_TIMEOUT);
        chk("t4_drop_off", vif.can_drop_o, 0);
        mon_active = 1'b0;
        issue(0, 1'b0);
        chk("t4_pend_1", vif.pend_o, 1);
        repeat (3) cycle();
        chk("t4_pend_hold", vif.pend_o, 1);
        chk("t4_no_nick", vif.nick_eject_o, 0);

        // Four nickels with a toggling ejector ready
        do_reset();
        auto_done  = 1'b1;
        toggle_rdy = 1'b1;
        issue(4, 1'b1);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (vif.nick_eject_o) cnt++;
        end
        chk("t5_pulses", cnt, 4);
        chk("t5_vend", vif.vend_cnt_o, 1);
        flush();

        // Reset in the middle of change ejection
        do_reset();
        auto_done        = 1'b1;
        vif.nick_ready_i = 1'b1;
        issue(3, 1'b1);
        cnt = 0;
        while (!vif.nick_eject_o && cnt < 60) begin
            cycle();
            cnt++;
        end
        chk("t6_first_pulse", vif.nick_eject_o, 1);
        mon_active = 1'b0;
        auto_done  = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_nick_async", vif.nick_eject_o, 0);
        chk("t6_drop_async", vif.can_drop_o, 0);
        chk("t6_vend_async", vif.vend_cnt_o, 0);
        chk("t6_busy_async", vif.busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        chk("t6_pend_after", vif.pend_o, 0);
        chk("t6_vend_after", vif.vend_cnt_o, 0);
        chk("t6_busy_after", vif.busy_o, 0);

        // Randomized purchases against the scoreboard
        do_reset();
        auto_done  = 1'b1;
        auto_ready = 1'b1;
        n_legal = 0;
        any_bad = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int c;
                c = $urandom_range(0, 7);
                if (c > 4) begin
                    any_bad = 1'b1;
                    vif.soda_i = 1'b1;
                    vif.chan_i = c[2:0];
                end else if (exp_q.size() < FIFO_DEPTH) begin
                    n_legal++;
                    exp_q.push_back(c);
                    vif.soda_i = 1'b1;
                    vif.chan_i = c[2:0];
                end
            end
            cycle();
            vif.soda_i = 1'b0;
        end
        cnt = 0;
        while ((exp_q.size() != 0 || vif.busy_o || vif.nick_eject_o) && cnt < 3000) begin
            cycle();
            cnt++;
        end
        repeat (3) cycle();
        chk("rnd_drained", (exp_q.size() == 0 && !vif.busy_o), 1);
        flush();
        chk("rnd_vend", vif.vend_cnt_o, n_legal);
        chk("rnd_code_err", vif.code_err_o, any_bad);
        chk("rnd_overflow", vif.overflow_o, 0);
        chk("rnd_fault", vif.fault_o, 0);
        chk("rnd_pend", vif.pend_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
